instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction fetch stage feeding the R-type datapath's 32-bit instruction input I.
//  Holds the 64-bit PC and a writable instruction memory with synchronous read.
//  Buffers fetched words in a small FIFO and presents them over a valid/ready handshake.
//  Supports PC redirect and flags misaligned or out-of-range fetches.
// PARAMETERS
//  IMEM_DEPTH  64  instruction memory depth in 32-bit words (power of 2)
//  RESET_PC    0   PC value loaded on reset (64-bit)
//  BUF_DEPTH   2   output FIFO entries (>=2, needed for full throughput)
// PORTS
//  clk             in   1                   rising-edge clock
//  rst             in   1                   asynchronous, active-high reset
//  fetch_en        in   1                   1 = fetching permitted
//  imem_we         in   1                   instruction memory write strobe
//  imem_waddr      in   $clog2(IMEM_DEPTH)  word address for write
//  imem_wdata      in   32                  word to write
//  redirect_valid  in   1                   load new PC; flush buffer and in-flight read
//  redirect_pc     in   64                  target PC
//  instr_ready     in   1                   consumer accepts head entry
//  instr_valid     out  1                   head entry valid
//  instr           out  32                  head instruction word
//  instr_pc        out  64                  PC of head instruction
//  fetch_err       out  1                   sticky fetch fault
// BEHAVIOUR
//  - One clock (clk). Async active-high reset (rst): pc=RESET_PC, state=IDLE, FIFO empty,
//    no read in flight. instr_valid=0, instr=0, instr_pc=0, fetch_err=0. IMEM contents untouched.
//  - FSM states:
//    - IDLE->FETCH when fetch_en=1.
//    - FETCH->IDLE when fetch_en=0.
//    - FETCH->ERR on a faulting issue attempt.
//    - ERR->FETCH only on redirect (also clears fetch_err). ERR otherwise holds until rst.
//  - Issue: in FETCH, if occupancy + inflight < BUF_DEPTH, read word pc[..:2] and set inflight.
//    pc <= pc+4 (64-bit wrap). At most one issue per cycle.
//  - Fault: issue attempt with pc[1:0]!=0 or pc >= 4*IMEM_DEPTH does not read.
//    It sets fetch_err=1 and enters ERR.
//  - Read data lands one cycle after issue. It is pushed into the FIFO with its PC.
//  - Latency: fetch_en seen high at edge N -> read at edge N+1 -> instr_valid=1 after edge N+2.
//  - Steady state: one instruction per cycle while instr_ready=1.
//  - Handshake: an entry pops when instr_valid && instr_ready.
//    instr/instr_pc hold stable while valid && !ready. Push and pop in the same cycle are legal.
//  - FIFO never overflows; issue is throttled by the occupancy + inflight rule.
//    Empty -> instr_valid=0, instr/instr_pc hold their last value.
//  - Redirect has priority over everything else in its cycle. It flushes the FIFO, cancels the
//    in-flight read (its data is discarded), and sets pc <= redirect_pc.
//    Same-cycle pop is void. The next issue is from redirect_pc in the following cycle.
//    Redirect in IDLE updates pc only.
//  - fetch_en dropped: no new issue; in-flight read still completes; FIFO keeps draining.
//  - IMEM write and read to the same address in one cycle: read returns the old word.
//    Writes are permitted in any state.
//  - rst mid-operation: immediate return to reset values; in-flight data is lost.
// TESTING
//  - Preload words 0..3 = 0x00A302B3,0x40A302B3,0x00A372B3,0x00A362B3; fetch_en=1, ready=1 ->
//    valid rises 2 cycles later; instr_pc 0,4,8,12 on consecutive cycles.
//  - Backpressure: ready=0 for 5 cycles mid-stream -> instr/instr_pc frozen, no PC skipped or
//    duplicated after ready returns, FIFO holds BUF_DEPTH.
//  - Redirect to 0x20 while a read is in flight -> no stale word shown; next valid has instr_pc=0x20.
//  - Redirect to 0x6 -> fetch_err=1, instr_valid drops after drain.
//    Redirect to 0x8 -> fetch_err=0, fetch resumes at 0x8.
//  - Run pc to 4*IMEM_DEPTH -> last word delivered, then fetch_err=1 with no extra instr_valid.
//  - Assert rst asynchronously mid-stream -> instr_valid=0 and fetch_err=0 before the next edge;
//    fetch restarts from RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: 64-bit PC, writable sync-read IMEM, small output FIFO with valid/ready.
// Latency: fetch_en seen at edge N -> IMEM read at N+1 -> instr_valid after N+2; 1 instr/cycle steady.
// Backpressure: issue throttled so FIFO occupancy (after this cycle's pop) + in-flight < BUF_DEPTH.
module instr_fetch_unit #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fetch_en,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  input  logic                          redirect_valid,
  input  logic [63:0]                   redirect_pc,
  input  logic                          instr_ready,
  output logic                          instr_valid,
  output logic [31:0]                   instr,
  output logic [63:0]                   instr_pc,
  output logic                          fetch_err
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [63:0] IMEM_BYTES = 64'(4 * IMEM_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, ERR} state_t;

  state_t        state;
  logic [63:0]   pc;
  logic          inflight;
  logic [63:0]   inflight_pc;
  logic [31:0]   rd_data;
  logic [31:0]   mem [IMEM_DEPTH];

  logic [31:0]   fifo_instr [BUF_DEPTH];
  logic [63:0]   fifo_pc    [BUF_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   hold_instr;
  logic [63:0]   hold_pc;

  logic          flush, pop, push, attempt, bad_pc, issue, fault;
  logic [CW:0]   occ_next;

  // Redirect outside IDLE flushes the buffer and the in-flight read; in IDLE it only moves pc.
  assign flush    = redirect_valid && (state != IDLE);
  assign instr_valid = (count != '0);
  assign pop      = instr_valid && instr_ready && !flush;
  assign push     = inflight && !flush;
  // Occupancy once this cycle's pop and landing read are accounted for.
  assign occ_next = {1'b0, count} - (CW+1)'(pop) + (CW+1)'(inflight);
  assign attempt  = (state == FETCH) && fetch_en && !redirect_valid &&
                    (occ_next < (CW+1)'(BUF_DEPTH));
  assign bad_pc   = (pc[1:0] != 2'b00) || (pc >= IMEM_BYTES);
  assign issue    = attempt && !bad_pc;
  assign fault    = attempt && bad_pc;

  // Head is shown while valid; when empty the last displayed word/PC is held.
  assign instr    = instr_valid ? fifo_instr[rd_ptr] : hold_instr;
  assign instr_pc = instr_valid ? fifo_pc[rd_ptr]    : hold_pc;

  // IMEM write port and synchronous read on issue; NBA ordering gives read-old-data on collision.
  always_ff @(posedge clk) begin
    if (imem_we) mem[imem_waddr] <= imem_wdata;
    if (issue)   rd_data <= mem[pc[AW+1:2]];
  end

  // Fetch FSM, PC sequencing, in-flight tracking and sticky fault flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      fetch_err   <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + 64'd4;
      end
      case (state)
        IDLE:    if (fetch_en) state <= FETCH;
        FETCH: begin
          if (fault) begin
            state     <= ERR;
            fetch_err <= 1'b1;
          end else if (!fetch_en) begin
            state <= IDLE;
          end
        end
        default: ;
      endcase
      if (redirect_valid) begin
        pc <= redirect_pc;
        if (state == IDLE) begin
          state <= IDLE;
        end else begin
          state     <= FETCH;
          fetch_err <= 1'b0;
        end
      end
    end
  end

  // Output FIFO: push landing read data, pop on handshake, flush on redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      hold_instr <= '0;
      hold_pc    <= '0;
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else begin
      if (instr_valid) begin
        hold_instr <= fifo_instr[rd_ptr];
        hold_pc    <= fifo_pc[rd_ptr];
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          fifo_instr[wr_ptr] <= rd_data;
          fifo_pc[wr_ptr]    <= inflight_pc;
          wr_ptr <= (wr_ptr == PW'(BUF_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= (rd_ptr == PW'(BUF_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule
